clk_lock_ctrl: RTL and testbench



---
 rtl/clk_lock_ctrl.sv | 104 ++++++++++
 tb/tb_clk_lock_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_lock_ctrl.sv
// clk_lock_ctrl: DCM reset/lock supervisor with timeout retry, settle window and lock-loss recovery
//   BUS_CLK/BUS_RST : clock, synchronous active-high reset
//   DCM_LOCKED      : asynchronous LOCKED from the DCM
//   SOFT_RST        : restart request (priority over all FSM conditions)
//   DCM_RST         : DCM reset pin, CLK_READY: clocks settled, FAIL: retries exhausted
//   STATE/RETRY_CNT/LOSS_CNT : status
module clk_lock_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int SETTLE_CYCLES = 256,
    parameter int MAX_RETRY     = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic       BUS_CLK,
    input  logic       BUS_RST,
    input  logic       DCM_LOCKED,
    input  logic       SOFT_RST,
    output logic       DCM_RST,
    output logic       CLK_READY,
    output logic       FAIL,
    output logic [2:0] STATE,
    output logic [3:0] RETRY_CNT,
    output logic [7:0] LOSS_CNT
);
    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_READY      = 3'd3,
        ST_FAIL       = 3'd4
    } state_t;
    state_t state, nxt;
    logic [1:0] sync;
    logic lk_s;
    logic last_try;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [3:0] retry_nxt;
    logic [7:0] loss_nxt;
    assign lk_s = sync[1];
    assign last_try = RETRY_CNT == 4'(MAX_RETRY - 1);
    assign STATE = state;
    always_comb begin
        nxt = state;
        retry_nxt = RETRY_CNT;
        loss_nxt = LOSS_CNT;
        case (state)
            ST_RESET_HOLD: nxt = (cnt == CNT_WIDTH'(RST_CYCLES - 1)) ? ST_WAIT_LOCK : state;
            ST_WAIT_LOCK: begin
                // a lock seen on the timeout cycle still wins
                if (lk_s) nxt = ST_SETTLE;
                else if (cnt == CNT_WIDTH'(LOCK_TIMEOUT - 1)) begin
                    nxt = last_try ? ST_FAIL : ST_RESET_HOLD;
                    retry_nxt = RETRY_CNT + 4'd1;
                end
            end
            ST_SETTLE: begin
                // losing lock while settling is a failed attempt, same as a timeout
                if (!lk_s) begin
                    nxt = last_try ? ST_FAIL : ST_RESET_HOLD;
                    retry_nxt = RETRY_CNT + 4'd1;
                end else if (cnt == CNT_WIDTH'(SETTLE_CYCLES - 1)) begin
                    nxt = ST_READY;
                    retry_nxt = 4'd0;
                end
            end
            ST_READY: begin
                if (!lk_s) begin
                    nxt = ST_RESET_HOLD;
                    loss_nxt = (LOSS_CNT == 8'hFF) ? LOSS_CNT : LOSS_CNT + 8'd1;
                end
            end
            ST_FAIL: nxt = state;
            default: nxt = ST_RESET_HOLD;
        endcase
        if (SOFT_RST) begin
            nxt = ST_RESET_HOLD;
            retry_nxt = 4'd0;
            loss_nxt = LOSS_CNT;
        end
        cnt_nxt = (nxt != state || SOFT_RST) ? '0 : cnt + CNT_WIDTH'(1);
    end
    // status outputs are decoded from the next state so they move on the same edge as STATE
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            sync <= 2'b00;
            state <= ST_RESET_HOLD;
            cnt <= '0;
            DCM_RST <= 1'b1;
            CLK_READY <= 1'b0;
            FAIL <= 1'b0;
            RETRY_CNT <= 4'd0;
            LOSS_CNT <= 8'd0;
        end else begin
            sync <= {sync[0], DCM_LOCKED};
            state <= nxt;
            cnt <= cnt_nxt;
            DCM_RST <= nxt == ST_RESET_HOLD;
            CLK_READY <= nxt == ST_READY;
            FAIL <= nxt == ST_FAIL;
            RETRY_CNT <= retry_nxt;
            LOSS_CNT <= loss_nxt;
        end
    end
endmodule

// File: tb/tb_clk_lock_ctrl.sv
// tb_clk_lock_ctrl: directed bench for clk_lock_ctrl with a phase/countdown reference model
module tb_clk_lock_ctrl;
    localparam int RST = 4, TO = 32, SET = 8, MR = 3;
    logic BUS_CLK = 1'b0, BUS_RST = 1'b1, DCM_LOCKED = 1'b0, SOFT_RST = 1'b0;
    logic DCM_RST, CLK_READY, FAIL;
    logic [2:0] STATE;
    logic [3:0] RETRY_CNT;
    logic [7:0] LOSS_CNT;
    int checks = 0, failures = 0;

    clk_lock_ctrl #(.RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .SETTLE_CYCLES(SET), .MAX_RETRY(MR), .CNT_WIDTH(16)) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .DCM_LOCKED(DCM_LOCKED), .SOFT_RST(SOFT_RST),
        .DCM_RST(DCM_RST), .CLK_READY(CLK_READY), .FAIL(FAIL), .STATE(STATE),
        .RETRY_CNT(RETRY_CNT), .LOSS_CNT(LOSS_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: phase number plus cycles remaining in that phase; lock seen through a 2-deep delay line
    int m_st, m_left, m_retry, m_loss;
    bit m_s0, m_s1, mv;

    task automatic enter(input int s);
        m_st = s;
        m_left = (s == 0) ? RST : (s == 1) ? TO : SET;
    endtask

    task automatic attempt_failed();
        m_retry++;
        enter(m_retry == MR ? 4 : 0);
    endtask

    always @(posedge BUS_CLK) begin
        bit ls;
        ls = m_s1;
        if (BUS_RST) begin
            m_s0 = 0;
            m_s1 = 0;
            m_retry = 0;
            m_loss = 0;
            enter(0);
            mv = 1;
        end else begin
            m_s1 = m_s0;
            m_s0 = DCM_LOCKED;
            if (SOFT_RST) begin
                m_retry = 0;
                enter(0);
            end else if (m_st == 0) begin
                m_left--;
                if (m_left == 0) enter(1);
            end else if (m_st == 1) begin
                if (ls) enter(2);
                else begin
                    m_left--;
                    if (m_left == 0) attempt_failed();
                end
            end else if (m_st == 2) begin
                if (!ls) attempt_failed();
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_retry = 0;
                        enter(3);
                    end
                end
            end else if (m_st == 3) begin
                if (!ls) begin
                    if (m_loss < 255) m_loss++;
                    enter(0);
                end
            end
        end
    end

    always @(negedge BUS_CLK) begin
        if (mv) begin
            chk("STATE", STATE, m_st);
            chk("DCM_RST", DCM_RST, m_st == 0);
            chk("CLK_READY", CLK_READY, m_st == 3);
            chk("FAIL_OUT", FAIL, m_st == 4);
            chk("RETRY_CNT", RETRY_CNT, m_retry);
            chk("LOSS_CNT", LOSS_CNT, m_loss);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge BUS_CLK);
    endtask

    task automatic pulse_soft();
        SOFT_RST = 1'b1;
        cyc(1);
        SOFT_RST = 1'b0;
    endtask

    task automatic wait_ready(input int lim);
        int n;
        n = 0;
        while (!CLK_READY && n < lim) begin
            cyc(1);
            n++;
        end
        chk("wait_ready", CLK_READY, 1);
    endtask

    initial begin
        cyc(3);
        chk("rst_state", STATE, 0);
        chk("rst_dcm", DCM_RST, 1);
        chk("rst_ready", CLK_READY, 0);
        chk("rst_loss", LOSS_CNT, 0);
        // nominal start
        BUS_RST = 1'b0;
        cyc(3);
        chk("nom_dcm_hi", DCM_RST, 1);
        cyc(1);
        chk("nom_dcm_lo", DCM_RST, 0);
        chk("nom_wait", STATE, 1);
        cyc(6);
        DCM_LOCKED = 1'b1;
        cyc(10);
        chk("nom_ready_early", CLK_READY, 0);
        cyc(1);
        chk("nom_ready", CLK_READY, 1);
        chk("nom_state", STATE, 3);
        chk("nom_retry", RETRY_CNT, 0);
        // timeouts to FAIL
        BUS_RST = 1'b1;
        DCM_LOCKED = 1'b0;
        cyc(2);
        BUS_RST = 1'b0;
        cyc(36);
        chk("to1_state", STATE, 0);
        chk("to1_retry", RETRY_CNT, 1);
        cyc(71);
        chk("to3_wait", STATE, 1);
        chk("to2_retry", RETRY_CNT, 2);
        cyc(1);
        chk("fail_state", STATE, 4);
        chk("fail_out", FAIL, 1);
        chk("fail_retry", RETRY_CNT, 3);
        chk("fail_dcm", DCM_RST, 0);
        cyc(20);
        chk("fail_hold", STATE, 4);
        pulse_soft();
        chk("soft_fail", FAIL, 0);
        chk("soft_retry", RETRY_CNT, 0);
        chk("soft_dcm", DCM_RST, 1);
        cyc(3);
        chk("soft_dcm_hi", DCM_RST, 1);
        cyc(1);
        chk("soft_dcm_lo", DCM_RST, 0);
        // lock loss in READY
        DCM_LOCKED = 1'b1;
        wait_ready(100);
        DCM_LOCKED = 1'b0;
        cyc(1);
        DCM_LOCKED = 1'b1;
        cyc(1);
        chk("loss_still_ready", STATE, 3);
        cyc(1);
        chk("loss_state", STATE, 0);
        chk("loss_ready", CLK_READY, 0);
        chk("loss_cnt", LOSS_CNT, 1);
        wait_ready(100);
        chk("loss_retry", RETRY_CNT, 0);
        // glitch during SETTLE
        pulse_soft();
        cyc(6);
        chk("glitch_settle", STATE, 2);
        DCM_LOCKED = 1'b0;
        cyc(1);
        DCM_LOCKED = 1'b1;
        cyc(2);
        chk("glitch_state", STATE, 0);
        chk("glitch_retry", RETRY_CNT, 1);
        wait_ready(100);
        chk("glitch_retry_clr", RETRY_CNT, 0);
        // lock arrives exactly on the timeout cycle
        DCM_LOCKED = 1'b0;
        pulse_soft();
        cyc(33);
        DCM_LOCKED = 1'b1;
        cyc(2);
        chk("edge_wait", STATE, 1);
        cyc(1);
        chk("edge_settle", STATE, 2);
        chk("edge_retry", RETRY_CNT, 0);
        wait_ready(100);
        // SOFT_RST coincident with lock loss
        DCM_LOCKED = 1'b0;
        cyc(1);
        DCM_LOCKED = 1'b1;
        cyc(1);
        SOFT_RST = 1'b1;
        cyc(1);
        SOFT_RST = 1'b0;
        chk("prio_state", STATE, 0);
        chk("prio_loss", LOSS_CNT, 1);
        wait_ready(100);
        // saturation
        repeat (260) begin
            DCM_LOCKED = 1'b0;
            cyc(1);
            DCM_LOCKED = 1'b1;
            cyc(2);
            wait_ready(100);
        end
        chk("sat_loss", LOSS_CNT, 255);
        // BUS_RST mid-SETTLE
        pulse_soft();
        cyc(6);
        chk("busrst_settle", STATE, 2);
        BUS_RST = 1'b1;
        cyc(1);
        chk("busrst_state", STATE, 0);
        chk("busrst_dcm", DCM_RST, 1);
        chk("busrst_ready", CLK_READY, 0);
        chk("busrst_fail", FAIL, 0);
        chk("busrst_retry", RETRY_CNT, 0);
        chk("busrst_loss", LOSS_CNT, 0);
        BUS_RST = 1'b0;
        cyc(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
